// File: rtl/jtframe_rom_2slots.sv
// Two-slot ROM front end for the frame SDRAM read port; each slot caches one 32-bit block.
// Hits answer one cycle after the address is sampled; misses are arbitrated (slot 0 first), one SDRAM read in flight.
module jtframe_rom_2slots #(
  parameter int          SLOT0_AW     = 17,
  parameter int          SLOT0_DW     = 8,
  parameter logic [21:0] SLOT0_OFFSET = 22'h0,
  parameter logic [1:0]  SLOT0_BANK   = 2'd0,
  parameter int          SLOT1_AW     = 15,
  parameter int          SLOT1_DW     = 16,
  parameter logic [21:0] SLOT1_OFFSET = 22'h0,
  parameter logic [1:0]  SLOT1_BANK   = 2'd1
) (
  input  logic                clk_rom,
  input  logic                rst,
  input  logic                downloading,
  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic [SLOT0_DW-1:0] slot0_dout,
  output logic                slot0_ok,
  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic [SLOT1_DW-1:0] slot1_dout,
  output logic                slot1_ok,
  output logic                sdram_req,
  output logic [21:0]         sdram_addr,
  output logic [1:0]          sdram_bank,
  input  logic                sdram_ack,
  input  logic [31:0]         data_read,
  input  logic                data_rdy
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  // Sub-block select bits: 2 for bytes, 1 for words, none for full blocks
  localparam int S0_SW  = (SLOT0_DW == 8) ? 2 : ((SLOT0_DW == 16) ? 1 : 0);
  localparam int S0_TW  = SLOT0_AW - S0_SW;
  localparam int S0_LDW = $clog2(SLOT0_DW);
  localparam int S1_SW  = (SLOT1_DW == 8) ? 2 : ((SLOT1_DW == 16) ? 1 : 0);
  localparam int S1_TW  = SLOT1_AW - S1_SW;
  localparam int S1_LDW = $clog2(SLOT1_DW);

  state_t      state_q;
  logic        req_q;
  logic [21:0] addr_q;
  logic [1:0]  bank_q;
  logic        owner_q;
  logic        abort_q;

  logic        issue, grant0, grant1, data_done, keep, fill0, fill1;

  // ---------------- slot 0 cache ----------------
  logic [S0_TW-1:0]    s0_tag, s0_tag_q, s0_pend_q;
  logic [31:0]         s0_data_q;
  logic                s0_valid_q, s0_valid_d;
  logic                s0_hit, s0_miss;
  logic [21:0]         s0_fetch;
  logic [4:0]          s0_shift;
  logic [SLOT0_DW-1:0] s0_sel, s0_dout_q;
  logic                s0_ok_q;

  assign s0_tag   = slot0_addr[SLOT0_AW-1:S0_SW];
  assign s0_hit   = slot0_cs & s0_valid_q & (s0_tag_q == s0_tag);
  assign s0_miss  = slot0_cs & ~s0_hit;
  assign s0_fetch = SLOT0_OFFSET + 22'({s0_tag, 1'b0});

  generate
    if (S0_SW == 0) begin : g_s0_full
      assign s0_shift = 5'd0;
    end else begin : g_s0_part
      assign s0_shift = 5'({slot0_addr[S0_SW-1:0], {S0_LDW{1'b0}}});
    end
  endgenerate

  assign s0_sel = s0_data_q[s0_shift +: SLOT0_DW];

  always_comb begin
    s0_valid_d = s0_valid_q;
    if (downloading) s0_valid_d = 1'b0;
    else if (fill0)  s0_valid_d = 1'b1;
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_tag_q   <= '0;
      s0_pend_q  <= '0;
      s0_data_q  <= '0;
      s0_dout_q  <= '0;
      s0_ok_q    <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_ok_q    <= s0_hit & ~downloading;
      s0_dout_q  <= s0_sel;
      if (grant0) s0_pend_q <= s0_tag;
      if (fill0) begin
        s0_data_q <= data_read;
        s0_tag_q  <= s0_pend_q;
      end
    end
  end

  assign slot0_dout = s0_dout_q;
  assign slot0_ok   = s0_ok_q;

  // ---------------- slot 1 cache ----------------
  logic [S1_TW-1:0]    s1_tag, s1_tag_q, s1_pend_q;
  logic [31:0]         s1_data_q;
  logic                s1_valid_q, s1_valid_d;
  logic                s1_hit, s1_miss;
  logic [21:0]         s1_fetch;
  logic [4:0]          s1_shift;
  logic [SLOT1_DW-1:0] s1_sel, s1_dout_q;
  logic                s1_ok_q;

  assign s1_tag   = slot1_addr[SLOT1_AW-1:S1_SW];
  assign s1_hit   = slot1_cs & s1_valid_q & (s1_tag_q == s1_tag);
  assign s1_miss  = slot1_cs & ~s1_hit;
  assign s1_fetch = SLOT1_OFFSET + 22'({s1_tag, 1'b0});

  generate
    if (S1_SW == 0) begin : g_s1_full
      assign s1_shift = 5'd0;
    end else begin : g_s1_part
      assign s1_shift = 5'({slot1_addr[S1_SW-1:0], {S1_LDW{1'b0}}});
    end
  endgenerate

  assign s1_sel = s1_data_q[s1_shift +: SLOT1_DW];

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (downloading) s1_valid_d = 1'b0;
    else if (fill1)  s1_valid_d = 1'b1;
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_pend_q  <= '0;
      s1_data_q  <= '0;
      s1_dout_q  <= '0;
      s1_ok_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ok_q    <= s1_hit & ~downloading;
      s1_dout_q  <= s1_sel;
      if (grant1) s1_pend_q <= s1_tag;
      if (fill1) begin
        s1_data_q <= data_read;
        s1_tag_q  <= s1_pend_q;
      end
    end
  end

  assign slot1_dout = s1_dout_q;
  assign slot1_ok   = s1_ok_q;

  // ---------------- SDRAM request FSM ----------------
  assign issue     = (state_q == IDLE) & ~downloading & (s0_miss | s1_miss);
  assign grant0    = issue & s0_miss;
  assign grant1    = issue & ~s0_miss & s1_miss;
  assign data_done = ((state_q == WAIT_ACK) & sdram_ack & data_rdy) |
                     ((state_q == WAIT_DATA) & data_rdy);
  // A download seen at any point of the transaction poisons its data
  assign keep      = data_done & ~abort_q & ~downloading;
  assign fill0     = keep & ~owner_q;
  assign fill1     = keep & owner_q;

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      bank_q  <= '0;
      owner_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (issue) begin
            req_q   <= 1'b1;
            owner_q <= ~s0_miss;
            addr_q  <= s0_miss ? s0_fetch : s1_fetch;
            bank_q  <= s0_miss ? SLOT0_BANK : SLOT1_BANK;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (downloading) abort_q <= 1'b1;
          if (sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= data_rdy ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (downloading) abort_q <= 1'b1;
          if (data_rdy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign sdram_bank = bank_q;

endmodule

// File: tb/tb_jtframe_rom_2slots.sv
// Scoreboarded bench: SDRAM contents are a lazily randomised word array; slot reads are predicted from it.
module tb_jtframe_rom_2slots;

  localparam logic [21:0] OFF0 = 22'h100000;
  localparam logic [21:0] OFF1 = 22'h000000;

  logic        clk_rom, rst, downloading;
  logic        slot0_cs, slot0_ok, slot1_cs, slot1_ok;
  logic [16:0] slot0_addr;
  logic [7:0]  slot0_dout;
  logic [14:0] slot1_addr;
  logic [15:0] slot1_dout;
  logic        sdram_req, sdram_ack, data_rdy;
  logic [21:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic [31:0] data_read;

  jtframe_rom_2slots #(
    .SLOT0_AW(17), .SLOT0_DW(8),  .SLOT0_OFFSET(OFF0), .SLOT0_BANK(2'd0),
    .SLOT1_AW(15), .SLOT1_DW(16), .SLOT1_OFFSET(OFF1), .SLOT1_BANK(2'd1)
  ) dut (
    .clk_rom(clk_rom), .rst(rst), .downloading(downloading),
    .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_dout(slot0_dout), .slot0_ok(slot0_ok),
    .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_dout(slot1_dout), .slot1_ok(slot1_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_ack(sdram_ack), .data_read(data_read), .data_rdy(data_rdy)
  );

  initial clk_rom = 1'b0;
  always #5 clk_rom = ~clk_rom;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SDRAM memory model
  logic [15:0] mem [logic [21:0]];

  function automatic logic [15:0] getw(input logic [21:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  // Scoreboard: one entry per sampled cycle, expected data derived from byte/word addressing
  typedef struct {
    bit          rst;
    bit          dl;
    bit          cs0;
    bit          cs1;
    logic [7:0]  e0;
    logic [15:0] e1;
  } ent_t;

  ent_t sbq[$];

  task automatic tick();
    ent_t        e;
    logic [21:0] wa;
    logic [15:0] w;
    e.rst = rst;
    e.dl  = downloading;
    e.cs0 = slot0_cs;
    e.cs1 = slot1_cs;
    wa    = OFF0 + 22'(slot0_addr >> 1);
    w     = getw(wa);
    e.e0  = slot0_addr[0] ? w[15:8] : w[7:0];
    wa    = OFF1 + 22'(slot1_addr);
    e.e1  = getw(wa);
    sbq.push_back(e);
    @(posedge clk_rom);
    #1;
  endtask

  ent_t me;
  bit   prev_req = 1'b0;

  always @(negedge clk_rom) begin
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      if (me.rst || me.dl || !me.cs0) chk("ok0_low", 32'(slot0_ok), 32'd0);
      else if (slot0_ok)              chk("dout0", 32'(slot0_dout), 32'(me.e0));
      if (me.rst || me.dl || !me.cs1) chk("ok1_low", 32'(slot1_ok), 32'd0);
      else if (slot1_ok)              chk("dout1", 32'(slot1_dout), 32'(me.e1));
      if (me.rst)     chk("rst_req_low", 32'(sdram_req), 32'd0);
      else if (me.dl) chk("dl_no_new_req", 32'(sdram_req & ~prev_req), 32'd0);
      prev_req = sdram_req;
    end
  end

  // SDRAM responder
  typedef struct {
    logic [1:0]  bank;
    logic [21:0] addr;
    time         gap;
  } req_t;

  req_t req_log[$];
  bit   rand_mode = 1'b0;
  int   ack_dly   = 3;
  int   rdy_wait  = 0;
  bit   same      = 1'b0;
  time  fill_t    = 0;

  initial begin
    logic [21:0] ra, ra1;
    logic [1:0]  rb;
    logic [31:0] d;
    int          ad, rw;
    bit          sm;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
    forever begin
      @(negedge clk_rom);
      if (rst || !sdram_req) continue;
      ra  = sdram_addr;
      rb  = sdram_bank;
      ra1 = ra + 22'd1;
      req_log.push_back('{rb, ra, $time - fill_t});
      if (rand_mode) begin
        ad = $urandom_range(0, 3);
        rw = $urandom_range(0, 3);
        sm = ($urandom_range(0, 3) == 0);
      end else begin
        ad = ack_dly;
        rw = rdy_wait;
        sm = same;
      end
      d = {getw(ra1), getw(ra)};
      repeat (ad) begin
        @(negedge clk_rom);
        chk("req_hold", {7'd0, sdram_req, sdram_bank, sdram_addr}, {7'd0, 1'b1, rb, ra});
      end
      @(posedge clk_rom);
      #1;
      sdram_ack = 1'b1;
      if (sm) begin
        data_rdy  = 1'b1;
        data_read = d;
      end
      @(posedge clk_rom);
      if (sm) fill_t = $time;
      #1;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      @(negedge clk_rom);
      chk("req_drop", 32'(sdram_req), 32'd0);
      if (!sm) begin
        repeat (rw) @(posedge clk_rom);
        #1;
        data_rdy  = 1'b1;
        data_read = d;
        @(posedge clk_rom);
        fill_t = $time;
        #1;
        data_rdy = 1'b0;
        @(negedge clk_rom);
        chk("idle_gap", 32'(sdram_req), 32'd0);
      end
    end
  end

  task automatic wait_ok(input int s, input int maxc);
    bit got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      tick();
      got = (s == 0) ? slot0_ok : slot1_ok;
    end
    chk(s == 0 ? "wait_ok0" : "wait_ok1", 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          nlog, n;
    logic [15:0] w;
    mem[22'h100002] = 16'hBBAA;
    mem[22'h100003] = 16'hDDCC;
    mem[22'h000012] = 16'h5678;
    mem[22'h000013] = 16'h1234;

    // Reset with both slots requesting
    rst         = 1'b1;
    downloading = 1'b0;
    slot0_cs    = 1'b1;
    slot0_addr  = 17'h00005;
    slot1_cs    = 1'b1;
    slot1_addr  = 15'h0013;
    repeat (3) begin
      tick();
      chk("reset_req", 32'(sdram_req), 32'd0);
    end

    // Simultaneous misses: slot 0 first, slot 1 right after its fill
    rst = 1'b0;
    tick();
    chk("first_req", 32'(sdram_req), 32'd1);
    chk("first_addr", 32'(sdram_addr), 32'h100002);
    chk("first_bank", 32'(sdram_bank), 32'd0);
    wait_ok(0, 40);
    chk("slot0_BB", 32'(slot0_dout), 32'hBB);
    wait_ok(1, 40);
    chk("slot1_1234", 32'(slot1_dout), 32'h1234);
    chk("req_count", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) begin
      chk("slot1_addr", 32'(req_log[1].addr), 32'h000012);
      chk("slot1_bank", 32'(req_log[1].bank), 32'd1);
      chk("b2b_gap", 32'(req_log[1].gap), 32'd15);
    end

    // Same block, other byte: hit without SDRAM traffic
    slot0_addr = 17'h00006;
    tick();
    chk("hit_ok", 32'(slot0_ok), 32'd1);
    chk("hit_CC", 32'(slot0_dout), 32'hCC);
    chk("hit_noreq", 32'(sdram_req), 32'd0);

    // Ack and data in the same cycle
    same       = 1'b1;
    ack_dly    = 1;
    slot1_cs   = 1'b0;
    slot0_addr = 17'h00041;
    nlog       = req_log.size();
    tick();
    wait_ok(0, 30);
    w = getw(OFF0 + 22'h20);
    chk("same_cyc_dout", 32'(slot0_dout), 32'(w[15:8]));
    chk("same_cyc_reqs", 32'(req_log.size() - nlog), 32'd1);

    // Download raised while waiting for data
    same       = 1'b0;
    ack_dly    = 0;
    rdy_wait   = 4;
    slot0_cs   = 1'b0;
    slot1_cs   = 1'b1;
    slot1_addr = 15'h0020;
    tick();
    chk("dl_req", 32'(sdram_req), 32'd1);
    chk("dl_req_addr", 32'(sdram_addr), 32'h000020);
    chk("dl_req_bank", 32'(sdram_bank), 32'd1);
    tick();
    tick();
    downloading = 1'b1;
    nlog        = req_log.size();
    repeat (10) tick();
    chk("dl_no_req", 32'(req_log.size() - nlog), 32'd0);
    chk("dl_ok1", 32'(slot1_ok), 32'd0);
    downloading = 1'b0;
    tick();
    chk("post_dl_req", 32'(sdram_req), 32'd1);
    wait_ok(1, 40);
    chk("post_dl_dout", 32'(slot1_dout), 32'(getw(OFF1 + 22'h20)));

    // Randomised traffic
    rand_mode = 1'b1;
    for (int it = 0; it < 300; it++) begin
      slot0_cs    = ($urandom_range(0, 7) != 0);
      slot0_addr  = ($urandom_range(0, 9) == 0) ? 17'($urandom) : 17'($urandom_range(0, 15));
      slot1_cs    = ($urandom_range(0, 7) != 0);
      slot1_addr  = ($urandom_range(0, 9) == 0) ? 15'($urandom) : 15'($urandom_range(0, 7));
      downloading = ($urandom_range(0, 19) == 0);
      n = $urandom_range(1, 10);
      repeat (n) tick();
    end

    downloading = 1'b0;
    slot0_cs    = 1'b0;
    slot1_cs    = 1'b0;
    repeat (20) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
